// File: rtl/board_clock_reset_sequencer.sv
// Brings up the two board PLLs and releases the memory, TMDS and system resets in order.
// Optional PLL_LOCK_WATCHDOG_EN adds lock timeout, bounded PLL retries and a FAULT latch.
module board_clock_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 32,
  parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
  parameter int unsigned MAX_RETRY           = 7
) (
  input  logic       CLK_27M,
  input  logic       RESET_n,
  input  logic       PLL_LOCK_MEM,
  input  logic       PLL_LOCK_TMDS,
  output logic       PLL_RESET,
  output logic       MEM_RESET_n,
  output logic       TMDS_RESET_n,
  output logic       SYS_RESET_n,
  output logic [2:0] RETRY_COUNT,
  output logic       FAULT
);

  localparam int unsigned RstW = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned StbW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned GapW = $clog2(STAGE_GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    StPllRst, StWaitLock, StStable, StRelMem, StRelTmds, StRun, StFault
  } state_e;

  state_e            state_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic [StbW-1:0]   stable_cnt_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic              mem_s1_q, mem_s2_q, tmds_s1_q, tmds_s2_q;
  logic              lock_ok;

  assign lock_ok = mem_s2_q & tmds_s2_q;

  always_ff @(posedge CLK_27M) begin
    if (!RESET_n) begin
      mem_s1_q  <= 1'b0;
      mem_s2_q  <= 1'b0;
      tmds_s1_q <= 1'b0;
      tmds_s2_q <= 1'b0;
    end else begin
      mem_s1_q  <= PLL_LOCK_MEM;
      mem_s2_q  <= mem_s1_q;
      tmds_s1_q <= PLL_LOCK_TMDS;
      tmds_s2_q <= tmds_s1_q;
    end
  end

`ifdef PLL_LOCK_WATCHDOG_EN
  localparam int unsigned ToW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q;
  logic [2:0]     retry_next;
  assign retry_next = (RETRY_COUNT == 3'd7) ? 3'd7 : RETRY_COUNT + 3'd1;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{32'(LOCK_TIMEOUT_CYCLES), 32'(MAX_RETRY)};
  assign RETRY_COUNT = 3'd0;
  assign FAULT       = 1'b0;
`endif

  always_ff @(posedge CLK_27M) begin
    if (!RESET_n) begin
      state_q      <= StPllRst;
      rst_cnt_q    <= '0;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      PLL_RESET    <= 1'b1;
      MEM_RESET_n  <= 1'b0;
      TMDS_RESET_n <= 1'b0;
      SYS_RESET_n  <= 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
      to_cnt_q     <= '0;
      RETRY_COUNT  <= 3'd0;
      FAULT        <= 1'b0;
`endif
    end else begin
      case (state_q)
        StPllRst: begin
          if (rst_cnt_q == RstW'(PLL_RST_CYCLES - 1)) begin
            state_q   <= StWaitLock;
            PLL_RESET <= 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
            to_cnt_q  <= '0;
`endif
          end else begin
            rst_cnt_q <= rst_cnt_q + RstW'(1);
          end
        end
        // The timeout spans both lock states and takes priority over lock progress.
        StWaitLock, StStable: begin
`ifdef PLL_LOCK_WATCHDOG_EN
          to_cnt_q <= to_cnt_q + ToW'(1);
          if (to_cnt_q == ToW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            RETRY_COUNT <= retry_next;
            PLL_RESET   <= 1'b1;
            if (retry_next >= 3'(MAX_RETRY)) begin
              state_q <= StFault;
              FAULT   <= 1'b1;
            end else begin
              state_q   <= StPllRst;
              rst_cnt_q <= '0;
            end
          end else
`endif
          if (state_q == StWaitLock) begin
            if (lock_ok) begin
              state_q      <= StStable;
              stable_cnt_q <= '0;
            end
          end else if (!lock_ok) begin
            state_q      <= StWaitLock;
            stable_cnt_q <= '0;
          end else if (stable_cnt_q == StbW'(LOCK_STABLE_CYCLES - 1)) begin
            state_q     <= StRelMem;
            MEM_RESET_n <= 1'b1;
            gap_cnt_q   <= '0;
          end else begin
            stable_cnt_q <= stable_cnt_q + StbW'(1);
          end
        end
        StRelMem, StRelTmds, StRun: begin
          if (!lock_ok) begin
            // Lock loss restarts the PLLs without counting as a retry.
            state_q      <= StPllRst;
            rst_cnt_q    <= '0;
            PLL_RESET    <= 1'b1;
            MEM_RESET_n  <= 1'b0;
            TMDS_RESET_n <= 1'b0;
            SYS_RESET_n  <= 1'b0;
          end else if (state_q != StRun) begin
            if (gap_cnt_q == GapW'(STAGE_GAP_CYCLES - 1)) begin
              gap_cnt_q <= '0;
              if (state_q == StRelMem) begin
                state_q      <= StRelTmds;
                TMDS_RESET_n <= 1'b1;
              end else begin
                state_q     <= StRun;
                SYS_RESET_n <= 1'b1;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GapW'(1);
            end
          end
        end
        StFault: begin
        end
        default: begin
          state_q      <= StPllRst;
          rst_cnt_q    <= '0;
          PLL_RESET    <= 1'b1;
          MEM_RESET_n  <= 1'b0;
          TMDS_RESET_n <= 1'b0;
          SYS_RESET_n  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_clock_reset_sequencer.sv
// Scoreboard bench: expected output edges are queued with their cycle when stimulus is
// applied and popped by a monitor as the DUT outputs change.
module tb_board_clock_reset_sequencer;

  localparam int unsigned PR = 4;
  localparam int unsigned LS = 8;
  localparam int unsigned SG = 2;
  localparam int unsigned LT = 40;
  localparam int unsigned MR = 2;

  localparam logic [3:0] KPllFall = 4'd0;
  localparam logic [3:0] KPllRise = 4'd1;
  localparam logic [3:0] KMem     = 4'd2;
  localparam logic [3:0] KTmds    = 4'd3;
  localparam logic [3:0] KSys     = 4'd4;
  localparam logic [3:0] KDomLow  = 4'd5;
  localparam logic [3:0] KRetry   = 4'd6;
  localparam logic [3:0] KFault   = 4'd7;

  logic       clk = 1'b0;
  logic       rst_n, lock_mem, lock_tmds;
  logic       pll_reset, mem_reset_n, tmds_reset_n, sys_reset_n, fault;
  logic [2:0] retry_count;

  always #5 clk = ~clk;

  board_clock_reset_sequencer #(
    .PLL_RST_CYCLES     (PR),
    .LOCK_STABLE_CYCLES (LS),
    .STAGE_GAP_CYCLES   (SG),
    .LOCK_TIMEOUT_CYCLES(LT),
    .MAX_RETRY          (MR)
  ) dut (
    .CLK_27M      (clk),
    .RESET_n      (rst_n),
    .PLL_LOCK_MEM (lock_mem),
    .PLL_LOCK_TMDS(lock_tmds),
    .PLL_RESET    (pll_reset),
    .MEM_RESET_n  (mem_reset_n),
    .TMDS_RESET_n (tmds_reset_n),
    .SYS_RESET_n  (sys_reset_n),
    .RETRY_COUNT  (retry_count),
    .FAULT        (fault)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event word: kind[31:28], value[27:24], cycle[23:0].
  function automatic logic [31:0] ev(input logic [3:0] k, input logic [3:0] v,
                                     input int unsigned c);
    return {k, v, c[23:0]};
  endfunction

  function automatic string kname(input logic [3:0] k);
    case (k)
      KPllFall: return "pll_fall";
      KPllRise: return "pll_rise";
      KMem:     return "mem_release";
      KTmds:    return "tmds_release";
      KSys:     return "sys_release";
      KDomLow:  return "domains_low";
      KRetry:   return "retry_count";
      KFault:   return "fault";
      default:  return "unknown";
    endcase
  endfunction

  task automatic push(input logic [3:0] k, input logic [3:0] v, input int unsigned c);
    exp_q.push_back(ev(k, v, c));
  endtask

  task automatic observe(input logic [3:0] k, input logic [3:0] v);
    logic [31:0] got;
    logic [31:0] e;
    got = ev(k, v, cyc);
    if (exp_q.size() == 0) begin
      check_eq({"unexpected_", kname(k)}, got, 32'hffff_ffff);
    end else begin
      e = exp_q.pop_front();
      check_eq(kname(e[31:28]), got, e);
    end
  endtask

  logic       mon_en = 1'b0;
  logic       p_pll, p_mem, p_tmds, p_sys, p_fault;
  logic [2:0] p_retry;

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_pll && !pll_reset) observe(KPllFall, 4'd0);
      if (!p_pll && pll_reset) observe(KPllRise, 4'd1);
      if (!p_mem && mem_reset_n) observe(KMem, 4'd1);
      if (!p_tmds && tmds_reset_n) observe(KTmds, 4'd1);
      if (!p_sys && sys_reset_n) observe(KSys, 4'd1);
      if ((p_mem && !mem_reset_n) || (p_tmds && !tmds_reset_n) || (p_sys && !sys_reset_n))
        observe(KDomLow, {1'b0, mem_reset_n, tmds_reset_n, sys_reset_n});
      if (retry_count !== p_retry) observe(KRetry, {1'b0, retry_count});
      if (fault !== p_fault) observe(KFault, {3'b0, fault});
    end
    p_pll   = pll_reset;
    p_mem   = mem_reset_n;
    p_tmds  = tmds_reset_n;
    p_sys   = sys_reset_n;
    p_retry = retry_count;
    p_fault = fault;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Locks rise now: sync (2) + WAIT_LOCK step (1) + stable count, then the stage gaps.
  task automatic raise_locks_expect_release();
    int unsigned c;
    lock_mem  = 1'b1;
    lock_tmds = 1'b1;
    c = cyc;
    push(KMem, 4'd1, c + 3 + LS);
    push(KTmds, 4'd1, c + 3 + LS + SG);
    push(KSys, 4'd1, c + 3 + LS + 2 * SG);
  endtask

  // Locks drop while running: restart 3 cycles later, PLL reset held PR cycles.
  task automatic drop_expect_restart(input logic drop_mem, input logic drop_tmds);
    int unsigned c;
    if (drop_mem) lock_mem = 1'b0;
    if (drop_tmds) lock_tmds = 1'b0;
    c = cyc;
    push(KPllRise, 4'd1, c + 3);
    push(KDomLow, 4'd0, c + 3);
    push(KPllFall, 4'd0, c + 3 + PR);
  endtask

  initial begin
    int unsigned c;
    rst_n     = 1'b0;
    lock_mem  = 1'b0;
    lock_tmds = 1'b0;
    tick(3);
    check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("rst_mem_reset_n", 32'(mem_reset_n), 32'd0);
    check_eq("rst_tmds_reset_n", 32'(tmds_reset_n), 32'd0);
    check_eq("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check_eq("rst_retry_count", 32'(retry_count), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    mon_en = 1'b1;

    // Nominal bring-up.
    rst_n = 1'b1;
    push(KPllFall, 4'd0, cyc + PR);
    tick(PR + 10);
    raise_locks_expect_release();
    tick(20);

    // Lock loss in RUN, then a one-cycle TMDS glitch at stable count 5 on the way back up.
    drop_expect_restart(1'b1, 1'b0);
    tick(10);
    lock_mem = 1'b1;
    c = cyc;
    tick(6);
    lock_tmds = 1'b0;
    tick(1);
    lock_tmds = 1'b1;
    push(KMem, 4'd1, c + 7 + 3 + LS);
    push(KTmds, 4'd1, c + 7 + 3 + LS + SG);
    push(KSys, 4'd1, c + 7 + 3 + LS + 2 * SG);
    tick(25);
    check_eq("run_retry_count", 32'(retry_count), 32'd0);
    check_eq("run_pll_reset", 32'(pll_reset), 32'd0);

`ifdef PLL_LOCK_WATCHDOG_EN
    // Locks stay low: two timeouts, the second one latching FAULT.
    drop_expect_restart(1'b1, 1'b1);
    c = cyc + 3 + PR;
    push(KPllRise, 4'd1, c + LT);
    push(KRetry, 4'd1, c + LT);
    push(KPllFall, 4'd0, c + LT + PR);
    push(KPllRise, 4'd1, c + 2 * LT + PR);
    push(KRetry, 4'd2, c + 2 * LT + PR);
    push(KFault, 4'd1, c + 2 * LT + PR);
    tick(3 + PR + 2 * LT + PR + 10);
    check_eq("fault_level", 32'(fault), 32'd1);
    check_eq("fault_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("fault_sys_reset_n", 32'(sys_reset_n), 32'd0);

    // One-cycle RESET_n clears FAULT and RETRY_COUNT and restarts the sequence.
    rst_n = 1'b0;
    push(KRetry, 4'd0, cyc + 1);
    push(KFault, 4'd0, cyc + 1);
    tick(1);
    rst_n = 1'b1;
    push(KPllFall, 4'd0, cyc + PR);
    tick(PR + 3);
    raise_locks_expect_release();
    tick(20);
`else
    // Without the watchdog the sequencer simply waits for lock.
    drop_expect_restart(1'b1, 1'b1);
    tick(200);
    check_eq("nowd_retry_count", 32'(retry_count), 32'd0);
    check_eq("nowd_fault", 32'(fault), 32'd0);
    check_eq("nowd_pll_reset", 32'(pll_reset), 32'd0);
    check_eq("nowd_mem_reset_n", 32'(mem_reset_n), 32'd0);
    raise_locks_expect_release();
    tick(20);
`endif
    check_eq("final_sys_reset_n", 32'(sys_reset_n), 32'd1);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
